neurochip_cfg_loader: RTL

NEUROCHIP_CFG_LOADER -- requirements
Module: neurochip_cfg_loader

---
 rtl/neurochip_cfg_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/neurochip_cfg_loader.sv
// Byte-stream to serial configuration-chain loader for the neuron array.
// Define NEUROCHIP_CFG_READBACK_EN to add the rb_valid/rb_data chain readback outputs.
module neurochip_cfg_loader #(
    parameter int unsigned TOTAL_BITS = 998,
    parameter int unsigned CNT_W      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       config_en,
    output logic       bs_out,
    input  logic       bs_return,
    output logic       reset_nn,
    output logic       busy,
    output logic       done
`ifdef NEUROCHIP_CFG_READBACK_EN
    ,
    output logic       rb_valid,
    output logic [7:0] rb_data
`endif
);

    if ((2 ** CNT_W) <= TOTAL_BITS) begin : g_cnt_w_check
        $error("CNT_W is too narrow to count TOTAL_BITS");
    end

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(TOTAL_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StArm,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == LastBit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 8'h00;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from state only, so an asynchronous reset clears them at once.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        config_en = 1'b0;
        bs_out    = 1'b0;
        reset_nn  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    idx_d   = 3'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                config_en = 1'b1;
                bs_out    = hold_q[idx_q];
                idx_d     = idx_q + 3'd1;
                cnt_d     = cnt_q + CNT_W'(1);
                // The chain end wins over the byte boundary; leftover bits are dropped.
                if (last_bit) begin
                    state_d = StArm;
                end else if (idx_q == 3'd7) begin
                    state_d = StFetch;
                end
            end
            StArm: begin
                reset_nn = 1'b1;
                state_d  = StFin;
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

`ifdef NEUROCHIP_CFG_READBACK_EN
    logic [7:0] cap_q, cap_d;
    logic [7:0] rb_data_q, rb_data_d;
    logic       rb_valid_q, rb_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= 8'h00;
            rb_data_q  <= 8'h00;
            rb_valid_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    // The low counter bits give the position within the returned byte; starting each
    // byte from zero leaves a trailing partial byte zero-padded.
    always_comb begin
        cap_d      = cap_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (config_en) begin
            cap_d              = (cnt_q[2:0] == 3'd0) ? 8'h00 : cap_q;
            cap_d[cnt_q[2:0]]  = bs_return;
            if ((cnt_q[2:0] == 3'd7) || last_bit) begin
                rb_data_d  = cap_d;
                rb_valid_d = 1'b1;
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`else
    logic unused_bs_return;
    assign unused_bs_return = bs_return;
`endif

endmodule
